apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 11 +
 rtl/apb_addr_decode.sv | 17 +
 rtl/apb_master_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type, APB direction constants and default bridge parameters
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam logic APB_WRITE = 1'b1;
  localparam logic APB_READ = 1'b0;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_SLV_AW = 5;
  localparam int DEF_NSLV = 2;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps a request address to a one-hot slave select and a decode error flag
module apb_addr_decode import apb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int SLV_AW = DEF_SLV_AW,
  parameter int NSLV = DEF_NSLV
) (
  input  logic [AW-1:0]   addr,
  output logic [NSLV-1:0] sel,
  output logic            decode_err
);
  logic [AW-1:0] idx;
  always_comb begin
    idx = addr >> SLV_AW;
    for (int i = 0; i < NSLV; i++) sel[i] = idx == AW'(i);
    decode_err = ~|sel;
  end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request to APB master bridge with per-slave address windows
// Optional APB_TIMEOUT_EN macro aborts an ACCESS phase after TIMEOUT cycles without pready.
module apb_master_bridge import apb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int SLV_AW = DEF_SLV_AW,
  parameter int NSLV = DEF_NSLV
`ifdef APB_TIMEOUT_EN
  , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [AW-1:0]      paddr,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
  output logic               penable,
  output logic [NSLV-1:0]    psel,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);
  state_e state_q, state_d;
  logic [NSLV-1:0] psel_q, psel_d, dec_sel;
  logic penable_q, penable_d, pwrite_q, pwrite_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic dec_err, sel_rdy, sel_err, done, err;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d, sel_rdata, rd;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  apb_addr_decode #(.AW(AW), .SLV_AW(SLV_AW), .NSLV(NSLV)) u_dec (
    .addr(req_addr), .sel(dec_sel), .decode_err(dec_err)
  );
  always_comb begin
    sel_rdy = |(pready & psel_q);
    sel_err = |(pslverr & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) sel_rdata |= psel_q[i] ? prdata[i*DW +: DW] : '0;
    state_d = state_q;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    done = sel_rdy;
    err = sel_err;
    rd = pwrite_q == APB_WRITE ? '0 : sel_rdata;
`ifdef APB_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        paddr_d = req_addr;
        pwdata_d = req_wdata;
        state_d = dec_err ? RESP : SETUP;
        psel_d = dec_err ? '0 : dec_sel;
        pwrite_d = dec_err ? APB_READ : req_write;
        rsp_valid_d = dec_err;
        rsp_err_d = dec_err;
        rsp_rdata_d = '0;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: begin
`ifdef APB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (!sel_rdy && cnt_q == CW'(TIMEOUT - 1)) begin
          done = 1'b1;
          err = 1'b1;
          rd = '0;
        end
`endif
        if (done) begin
          psel_d = '0;
          penable_d = 1'b0;
          pwrite_d = APB_READ;
          state_d = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d = err;
          rsp_rdata_d = rd;
        end
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      psel_q <= '0;
      penable_q <= 1'b0;
      pwrite_q <= APB_READ;
      paddr_q <= '0;
      pwdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign req_ready = state_q == IDLE;
  assign psel = psel_q;
  assign penable = penable_q;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule
